sig_capture: RTL and testbench

Sample-capture block: the receive-side counterpart of the DAC waveform generator. It takes a 14-bit ADC stream and waits for a level-crossing trigger. It then writes 1024 decimated samples into an internal buffer and flags completion. The VGA trace renderer reads the buffer back through a registered random-access port.

---
 rtl/sig_capture_pkg.sv | 15 +
 rtl/capture_ram.sv | 33 +++
 rtl/sig_capture.sv | 142 ++++++++++++++
 tb/tb_sig_capture.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sig_capture_pkg.sv
// Shared types and sizing constants for the sig_capture sample-capture block.
package sig_capture_pkg;

   localparam int unsigned CAP_DATA_W = 14;
   localparam int unsigned CAP_ADDR_W = 10;
   localparam int unsigned CAP_DEPTH  = 1024;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARMED,
      ST_CAPTURE,
      ST_DONE
   } cap_state_t;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port capture buffer: one clock, registered read, old data returned on
// a same-address read/write collision.
module capture_ram
   import sig_capture_pkg::*;
#(
   parameter int unsigned DATA_W = CAP_DATA_W,
   parameter int unsigned ADDR_W = CAP_ADDR_W
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];
   logic [DATA_W-1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   // Array is read before the same-edge write lands, giving read-old behaviour.
   always_ff @(posedge i_clk) begin
      if (i_rst) r_rdata <= '0;
      else       r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/sig_capture.sv
// Level-crossing triggered, decimated ADC capture into a 1024-word buffer.
// Optional auto-trigger timeout enabled by defining SIG_CAPTURE_TIMEOUT_EN.
module sig_capture
   import sig_capture_pkg::*;
#(
   parameter int unsigned DATA_W         = CAP_DATA_W,
   parameter int unsigned ADDR_W         = CAP_ADDR_W,
   parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
   input  logic              clk_adc,
   input  logic              reset,
   input  logic              enable,
   input  logic              arm,
   input  logic [DATA_W-1:0] adc_data,
   input  logic [DATA_W-1:0] trig_level,
   input  logic              trig_slope,
   input  logic [3:0]        time_division,
   input  logic [ADDR_W-1:0] read_addr,
   output logic [DATA_W-1:0] read_data,
   output logic              busy,
   output logic              finished,
   output logic              triggered
);

   cap_state_t        r_state;
   logic [DATA_W-1:0] r_prev;
   logic              r_prev_valid;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [3:0]        r_dec_cnt;
   logic [3:0]        r_td;
   logic              r_busy;
   logic              r_finished;
   logic              r_triggered;

   logic              w_rise;
   logic              w_fall;
   logic              w_level_trig;
   logic              w_force;
   logic              w_start;
   logic              w_dec_wrap;
   logic              w_cap_wr;
   logic              w_we;
   logic [ADDR_W-1:0] w_waddr;

   always_comb begin
      w_rise       = (r_prev < trig_level) && (adc_data >= trig_level);
      w_fall       = (r_prev > trig_level) && (adc_data <= trig_level);
      w_level_trig = (r_state == ST_ARMED) && enable && r_prev_valid &&
                     (trig_slope ? w_fall : w_rise);
      w_start      = w_level_trig || w_force;
      w_dec_wrap   = (r_dec_cnt == r_td);
      w_cap_wr     = (r_state == ST_CAPTURE) && enable && w_dec_wrap;
      w_we         = !reset && (w_start || w_cap_wr);
      w_waddr      = w_start ? '0 : r_wr_addr;
   end

`ifdef SIG_CAPTURE_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [TMO_W-1:0] r_tmo_cnt;

   assign w_force = (r_state == ST_ARMED) && enable &&
                    (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk_adc) begin
      if (reset || (r_state != ST_ARMED)) r_tmo_cnt <= '0;
      else if (enable)                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
   end
`else
   assign w_force = 1'b0;
`endif

   always_ff @(posedge clk_adc) begin
      r_prev <= adc_data;
      if (reset) begin
         r_state      <= ST_IDLE;
         r_prev_valid <= 1'b0;
         r_wr_addr    <= '0;
         r_dec_cnt    <= '0;
         r_td         <= '0;
         r_busy       <= 1'b0;
         r_finished   <= 1'b0;
         r_triggered  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (arm) begin
                  r_state      <= ST_ARMED;
                  r_prev_valid <= 1'b0;
                  r_triggered  <= 1'b0;
                  r_busy       <= 1'b1;
                  r_finished   <= 1'b0;
               end
            end
            ST_ARMED: begin
               if (enable) r_prev_valid <= 1'b1;
               // Trigger sample goes to address 0 this edge; capture resumes at 1.
               if (w_start) begin
                  r_state     <= ST_CAPTURE;
                  r_wr_addr   <= ADDR_W'(1);
                  r_dec_cnt   <= '0;
                  r_td        <= time_division;
                  r_triggered <= w_level_trig;
               end
            end
            ST_CAPTURE: begin
               if (enable) begin
                  if (w_dec_wrap) begin
                     r_dec_cnt <= '0;
                     r_wr_addr <= r_wr_addr + 1'b1;
                     if (&r_wr_addr) begin
                        r_state    <= ST_DONE;
                        r_busy     <= 1'b0;
                        r_finished <= 1'b1;
                     end
                  end else begin
                     r_dec_cnt <= r_dec_cnt + 1'b1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   capture_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .i_clk   (clk_adc),
      .i_rst   (reset),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (adc_data),
      .i_raddr (read_addr),
      .o_rdata (read_data)
   );

   assign busy      = r_busy;
   assign finished  = r_finished;
   assign triggered = r_triggered;

endmodule

// File: tb/tb_sig_capture.sv
// Directed self-checking bench for sig_capture; timeout scenario follows SIG_CAPTURE_TIMEOUT_EN.
module tb_sig_capture;

   localparam int DW = 14;
   localparam int AW = 10;

   logic          clk_adc = 1'b0;
   logic          reset;
   logic          enable;
   logic          arm;
   logic [DW-1:0] adc_data;
   logic [DW-1:0] trig_level;
   logic          trig_slope;
   logic [3:0]    time_division;
   logic [AW-1:0] read_addr;
   logic [DW-1:0] read_data;
   logic          busy;
   logic          finished;
   logic          triggered;

   logic          ramp_en;
   int            total = 0;
   int            bad   = 0;

   always #5 clk_adc = ~clk_adc;

   sig_capture #(
      .DATA_W         (DW),
      .ADDR_W         (AW),
      .TIMEOUT_CYCLES (64)
   ) dut (
      .clk_adc       (clk_adc),
      .reset         (reset),
      .enable        (enable),
      .arm           (arm),
      .adc_data      (adc_data),
      .trig_level    (trig_level),
      .trig_slope    (trig_slope),
      .time_division (time_division),
      .read_addr     (read_addr),
      .read_data     (read_data),
      .busy          (busy),
      .finished      (finished),
      .triggered     (triggered)
   );

   task automatic step();
      @(posedge clk_adc);
      #1;
      if (ramp_en) adc_data = adc_data + 1'b1;
   endtask

   task automatic rd(input int a, output logic [DW-1:0] d);
      read_addr = AW'(a);
      step();
      d = read_data;
   endtask

   task automatic do_arm();
      arm = 1'b1;
      step();
      arm = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (finished !== 1'b0)  begin bad++; $display("FAIL reset_finished got=%b exp=0", finished); end
      total++; if (triggered !== 1'b0) begin bad++; $display("FAIL reset_triggered got=%b exp=0", triggered); end
      total++; if (read_data !== '0)   begin bad++; $display("FAIL reset_read_data got=%0d exp=0", read_data); end
      reset = 1'b0;
      step();
   endtask

   task automatic test_trigger_fill();
      int n;
      logic [DW-1:0] d;
      int addrs[4] = '{0, 1, 512, 1023};
      int exps[4]  = '{8192, 8193, 8704, 9215};
      trig_level = 14'd8192; trig_slope = 1'b0; time_division = 4'd0;
      adc_data = 14'd8150; ramp_en = 1'b1;
      do_arm();
      total++; if (busy !== 1'b1 || finished !== 1'b0)
         begin bad++; $display("FAIL fill_arm_busy got=%b/%b exp=1/0", busy, finished); end
      n = 0;
      do begin step(); n++; end while (finished !== 1'b1 && n < 5000);
      total++; if (n !== 1065) begin bad++; $display("FAIL fill_latency got=%0d exp=1065", n); end
      total++; if (triggered !== 1'b1 || busy !== 1'b0)
         begin bad++; $display("FAIL fill_flags got=%b/%b exp=1/0", triggered, busy); end
      for (int i = 0; i < 4; i++) begin
         rd(addrs[i], d);
         total++; if (d !== DW'(exps[i]))
            begin bad++; $display("FAIL fill_addr%0d got=%0d exp=%0d", addrs[i], d, exps[i]); end
      end
   endtask

   task automatic test_decimation();
      int n;
      logic [DW-1:0] d;
      int addrs[4] = '{0, 1, 100, 1023};
      int exps[4]  = '{8192, 8196, 8592, 12284};
      time_division = 4'd3;
      adc_data = 14'd8150;
      do_arm();
      total++; if (finished !== 1'b0 || busy !== 1'b1)
         begin bad++; $display("FAIL rearm_flags got=%b/%b exp=0/1", finished, busy); end
      n = 0;
      do begin
         step(); n++;
         if (n == 300) time_division = 4'd7;
      end while (finished !== 1'b1 && n < 10000);
      time_division = 4'd0;
      total++; if (n !== 4134) begin bad++; $display("FAIL dec_latency got=%0d exp=4134", n); end
      for (int i = 0; i < 4; i++) begin
         rd(addrs[i], d);
         total++; if (d !== DW'(exps[i]))
            begin bad++; $display("FAIL dec_addr%0d got=%0d exp=%0d", addrs[i], d, exps[i]); end
      end
   endtask

   task automatic test_falling_guard();
      int n;
      logic [DW-1:0] d;
      ramp_en = 1'b0; time_division = 4'd0;
      trig_level = 14'd50; trig_slope = 1'b1;
      adc_data = 14'd100;
      do_arm();
      adc_data = 14'd10;
      repeat (6) step();
      total++; if (triggered !== 1'b0 || busy !== 1'b1 || finished !== 1'b0)
         begin bad++; $display("FAIL guard_no_trig got=%b/%b/%b exp=0/1/0", triggered, busy, finished); end
      adc_data = 14'd100;
      step();
      adc_data = 14'd10;
      step();
      total++; if (triggered !== 1'b1) begin bad++; $display("FAIL fall_trig got=%b exp=1", triggered); end
      n = 0;
      do begin step(); n++; end while (finished !== 1'b1 && n < 3000);
      total++; if (n !== 1023) begin bad++; $display("FAIL fall_latency got=%0d exp=1023", n); end
      rd(0, d);
      total++; if (d !== 14'd10) begin bad++; $display("FAIL fall_addr0 got=%0d exp=10", d); end
   endtask

   task automatic test_enable_abort();
      int n;
      logic [DW-1:0] d;
      int addrs[3] = '{300, 301, 1023};
      int exps[3]  = '{8492, 8513, 9235};
      int aaddr[4] = '{0, 499, 500, 1023};
      int aexp[4]  = '{8160, 8659, 8712, 9235};
      trig_level = 14'd8192; trig_slope = 1'b0; time_division = 4'd0;
      adc_data = 14'd8150; ramp_en = 1'b1;
      do_arm();
      n = 0;
      do begin
         arm    = (n == 150);
         enable = !(n >= 342 && n < 362);
         step(); n++;
      end while (finished !== 1'b1 && n < 5000);
      arm = 1'b0; enable = 1'b1;
      total++; if (n !== 1085) begin bad++; $display("FAIL gate_latency got=%0d exp=1085", n); end
      for (int i = 0; i < 3; i++) begin
         rd(addrs[i], d);
         total++; if (d !== DW'(exps[i]))
            begin bad++; $display("FAIL gate_addr%0d got=%0d exp=%0d", addrs[i], d, exps[i]); end
      end
      trig_level = 14'd8160;
      adc_data = 14'd8150;
      do_arm();
      repeat (509) step();
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy_before got=%b exp=1", busy); end
      reset = 1'b1; arm = 1'b1;
      step();
      reset = 1'b0; arm = 1'b0;
      total++; if (busy !== 1'b0 || finished !== 1'b0 || triggered !== 1'b0)
         begin bad++; $display("FAIL abort_idle got=%b/%b/%b exp=0/0/0", busy, finished, triggered); end
      for (int i = 0; i < 4; i++) begin
         rd(aaddr[i], d);
         total++; if (d !== DW'(aexp[i]))
            begin bad++; $display("FAIL abort_addr%0d got=%0d exp=%0d", aaddr[i], d, aexp[i]); end
      end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_stays_idle got=%b exp=0", busy); end
   endtask

   task automatic test_timeout();
      int n;
      logic [DW-1:0] d;
      ramp_en = 1'b0; adc_data = 14'd5000;
      trig_level = 14'd8192; trig_slope = 1'b0; time_division = 4'd0;
      do_arm();
`ifdef SIG_CAPTURE_TIMEOUT_EN
      n = 0;
      do begin step(); n++; end while (finished !== 1'b1 && n < 3000);
      total++; if (n !== 1087) begin bad++; $display("FAIL timeout_latency got=%0d exp=1087", n); end
      total++; if (triggered !== 1'b0) begin bad++; $display("FAIL timeout_triggered got=%b exp=0", triggered); end
      rd(0, d);
      total++; if (d !== 14'd5000) begin bad++; $display("FAIL timeout_addr0 got=%0d exp=5000", d); end
`else
      repeat (200) step();
      rd(0, d);
      total++; if (busy !== 1'b1 || finished !== 1'b0 || triggered !== 1'b0)
         begin bad++; $display("FAIL no_timeout got=%b/%b/%b exp=1/0/0", busy, finished, triggered); end
      total++; if (d !== 14'd8160) begin bad++; $display("FAIL no_timeout_addr0 got=%0d exp=8160", d); end
`endif
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; enable = 1'b1; arm = 1'b0;
      adc_data = '0; trig_level = '0; trig_slope = 1'b0;
      time_division = 4'd0; read_addr = '0; ramp_en = 1'b0;
      test_reset();
      test_trigger_fill();
      test_decimation();
      test_falling_guard();
      test_enable_abort();
      test_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
